// File: rtl/shared_ram_arbiter_pkg.sv
// Shared definitions for the shared RAM arbiter: FSM state encoding and the
// requester ids used for arbitration and for routing read data / ACKs.
package shared_ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic REQ_MAIN = 1'b0;
  localparam logic REQ_SUB  = 1'b1;

endpackage

// File: rtl/shared_ram_arbiter_if.sv
// Bus bundle between the two CPU request ports, the arbiter and the
// single-port RAM.
//  slave  : arbiter side (CPU requests and RAM read data in; DI/ACK, RAM
//           controls and BUSY out)
//  master : environment side (CPUs + RAM), mirror image of slave
interface shared_ram_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          M_REQ, M_WE, M_ACK;
  logic [AW-1:0] M_AD;
  logic [DW-1:0] M_DO, M_DI;
  logic          S_REQ, S_WE, S_ACK;
  logic [AW-1:0] S_AD;
  logic [DW-1:0] S_DO, S_DI;
  logic [AW-1:0] RAM_AD;
  logic [DW-1:0] RAM_WD, RAM_RD;
  logic          RAM_WE;
  logic          BUSY;

  modport slave (
    input  M_REQ, M_WE, M_AD, M_DO, S_REQ, S_WE, S_AD, S_DO, RAM_RD,
    output M_DI, M_ACK, S_DI, S_ACK, RAM_AD, RAM_WD, RAM_WE, BUSY
  );

  modport master (
    output M_REQ, M_WE, M_AD, M_DO, S_REQ, S_WE, S_AD, S_DO, RAM_RD,
    input  M_DI, M_ACK, S_DI, S_ACK, RAM_AD, RAM_WD, RAM_WE, BUSY
  );
endinterface

// File: rtl/shared_ram_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way picker.
//  elig_i       : eligible requesters, indexed by REQ_MAIN / REQ_SUB
//  last_grant_i : id of the previous winner
//  prio_main_i  : 1 = main wins every tie, 0 = round-robin on ties
//  gnt_id_o     : winning requester id (meaningful when gnt_vld_o)
//  gnt_vld_o    : at least one requester eligible
module rr_arb2
  import shared_ram_arb_pkg::*;
(
  input  logic [1:0] elig_i,
  input  logic       last_grant_i,
  input  logic       prio_main_i,
  output logic       gnt_id_o,
  output logic       gnt_vld_o
);

  always_comb begin
    gnt_vld_o = |elig_i;
    gnt_id_o  = REQ_MAIN;
    if (elig_i[REQ_MAIN] && elig_i[REQ_SUB])
      gnt_id_o = prio_main_i ? REQ_MAIN : ~last_grant_i;
    else if (elig_i[REQ_SUB])
      gnt_id_o = REQ_SUB;
  end

endmodule

// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter: serializes main/sub CPU accesses onto one single-port
// RAM. Each access runs IDLE -> ACCESS -> DONE, and the winner's ACK pulses
// in the cycle after DONE, so one access completes every 3 cycles.
//  MCLK  : clock
//  RESET : synchronous, active-high
//  bus   : shared_ram_arbiter_if.slave (CPU request ports, RAM port, BUSY)
// Build option: define SHARED_RAM_MAIN_PRIO_EN to make ties go to the main CPU
// (fixed priority); otherwise ties alternate (round-robin).
module shared_ram_arbiter
  import shared_ram_arb_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic                 MCLK,
  input  logic                 RESET,
  shared_ram_arbiter_if.slave  bus
);

`ifdef SHARED_RAM_MAIN_PRIO_EN
  localparam logic PRIO_MAIN = 1'b1;
`else
  localparam logic PRIO_MAIN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;        // current/last winner
  logic          wr_q, wr_d;          // access in flight is a write
  logic [AW-1:0] ram_ad_q, ram_ad_d;
  logic [DW-1:0] ram_wd_q, ram_wd_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] m_di_q, m_di_d, s_di_q, s_di_d;
  logic          m_ack_q, m_ack_d, s_ack_q, s_ack_d;

  logic [1:0]    elig;
  logic          arb_id, arb_vld;

  // A requester in its ACK cycle still has REQ high; mask it so the same
  // request is not granted twice.
  assign elig = {bus.S_REQ & ~s_ack_q, bus.M_REQ & ~m_ack_q};

  rr_arb2 u_arb (
    .elig_i       (elig),
    .last_grant_i (gnt_q),
    .prio_main_i  (PRIO_MAIN),
    .gnt_id_o     (arb_id),
    .gnt_vld_o    (arb_vld)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    ram_ad_d = ram_ad_q;
    ram_wd_d = ram_wd_q;
    ram_we_d = ram_we_q;
    m_di_d   = m_di_q;
    s_di_d   = s_di_q;
    m_ack_d  = 1'b0;
    s_ack_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          gnt_d    = arb_id;
          wr_d     = (arb_id == REQ_MAIN) ? bus.M_WE : bus.S_WE;
          ram_we_d = wr_d;
          ram_ad_d = (arb_id == REQ_MAIN) ? bus.M_AD : bus.S_AD;
          ram_wd_d = (arb_id == REQ_MAIN) ? bus.M_DO : bus.S_DO;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ram_we_d = 1'b0;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        // RAM_RD now holds the word addressed during ACCESS
        if (!wr_q) begin
          if (gnt_q == REQ_MAIN) m_di_d = bus.RAM_RD;
          else                   s_di_d = bus.RAM_RD;
        end
        m_ack_d = (gnt_q == REQ_MAIN);
        s_ack_d = (gnt_q == REQ_SUB);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      gnt_q    <= REQ_SUB;
      wr_q     <= 1'b0;
      ram_ad_q <= '0;
      ram_wd_q <= '0;
      ram_we_q <= 1'b0;
      m_di_q   <= '0;
      s_di_q   <= '0;
      m_ack_q  <= 1'b0;
      s_ack_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      ram_ad_q <= ram_ad_d;
      ram_wd_q <= ram_wd_d;
      ram_we_q <= ram_we_d;
      m_di_q   <= m_di_d;
      s_di_q   <= s_di_d;
      m_ack_q  <= m_ack_d;
      s_ack_q  <= s_ack_d;
    end
  end

  assign bus.M_DI   = m_di_q;
  assign bus.S_DI   = s_di_q;
  assign bus.M_ACK  = m_ack_q;
  assign bus.S_ACK  = s_ack_q;
  assign bus.RAM_AD = ram_ad_q;
  assign bus.RAM_WD = ram_wd_q;
  assign bus.RAM_WE = ram_we_q;
  assign bus.BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Bench for shared_ram_arbiter: RAM model, transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then a
// randomized phase (requests, mid-request field changes, early REQ drops,
// reset pulses).
module tb_shared_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic MCLK = 1'b0;
  logic RESET;

  shared_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  shared_ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .MCLK  (MCLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 MCLK = ~MCLK;

  // ---------------- single-port synchronous RAM ----------------
  logic [DW-1:0] ram [1<<AW] = '{default: '0};
  logic [DW-1:0] ram_rd_q = '0;
  always @(posedge MCLK) begin
    if (bus.RAM_WE) ram[bus.RAM_AD] <= bus.RAM_WD;
    ram_rd_q <= ram[bus.RAM_AD];
  end
  assign bus.RAM_RD = ram_rd_q;

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // One transaction at a time, described by its grant cycle g:
  // BUSY in g+1..g+2, RAM_WE in g+1 for writes, ACK and new DI visible in g+3,
  // next grant possible from g+3. Memory order = grant order.
  int            cyc = 0;
  bit            model_on = 1'b0;
  bit            tx_vld = 1'b0;
  int            tx_g = 0;
  bit            tx_who = 1'b0;
  bit            tx_we = 1'b0;
  logic [DW-1:0] tx_rd = '0;
  bit            last = 1'b1;
  logic [AW-1:0] e_ad = '0;
  logic [DW-1:0] e_wd = '0, e_mdi = '0, e_sdi = '0;
  logic [DW-1:0] shadow [1<<AW] = '{default: '0};

  function automatic bit e_ack(input bit who, input int n);
    return tx_vld && (tx_who == who) && (n == tx_g + 3);
  endfunction
  function automatic bit e_busy(input int n);
    return tx_vld && ((n == tx_g + 1) || (n == tx_g + 2));
  endfunction
  function automatic bit e_we(input int n);
    return tx_vld && tx_we && (n == tx_g + 1);
  endfunction

  always @(posedge MCLK) begin : model
    int c;
    bit em, es, who;
    c = cyc;
    cyc = cyc + 1;
    if (RESET) begin
      model_on = 1'b1;
      tx_vld = 1'b0;
      last = 1'b1;
      e_ad = '0; e_wd = '0; e_mdi = '0; e_sdi = '0;
    end else if (model_on) begin
      if (tx_vld && (cyc == tx_g + 3) && !tx_we) begin
        if (tx_who) e_sdi = tx_rd;
        else        e_mdi = tx_rd;
      end
      em = bus.M_REQ && !e_ack(1'b0, c);
      es = bus.S_REQ && !e_ack(1'b1, c);
      if ((!tx_vld || c >= tx_g + 3) && (em || es)) begin
`ifdef SHARED_RAM_MAIN_PRIO_EN
        who = em ? 1'b0 : 1'b1;
`else
        who = (em && es) ? !last : es;
`endif
        tx_vld = 1'b1;
        tx_g   = c;
        tx_who = who;
        tx_we  = who ? bus.S_WE : bus.M_WE;
        e_ad   = who ? bus.S_AD : bus.M_AD;
        e_wd   = who ? bus.S_DO : bus.M_DO;
        if (tx_we) shadow[e_ad] = e_wd;
        else       tx_rd = shadow[e_ad];
        last = who;
      end
    end
  end

  always @(negedge MCLK) begin
    if (model_on) begin
      chk("outputs", {bus.M_ACK, bus.S_ACK, bus.BUSY, bus.RAM_WE, bus.RAM_AD, bus.RAM_WD, bus.M_DI, bus.S_DI},
          {e_ack(1'b0, cyc), e_ack(1'b1, cyc), e_busy(cyc), e_we(cyc), e_ad, e_wd, e_mdi, e_sdi});
      chk("ack_exclusive", bus.M_ACK & bus.S_ACK, 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic set_m(input bit req, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    bus.M_REQ = req; bus.M_WE = we; bus.M_AD = ad; bus.M_DO = d;
  endtask

  task automatic set_s(input bit req, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    bus.S_REQ = req; bus.S_WE = we; bus.S_AD = ad; bus.S_DO = d;
  endtask

  // Cycles until the requester's ACK; -1 if the budget runs out.
  task automatic wait_ack(input bit who, input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((who ? bus.S_ACK : bus.M_ACK) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [AW-1:0] ad_pick();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 3));
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    bit seq[$];
    bit first_sub;

    RESET = 1'b1;
    set_m(0, 0, '0, '0);
    set_s(0, 0, '0, '0);
    tick(); tick();
    chk("reset_m_ack", bus.M_ACK, 0);
    chk("reset_busy", bus.BUSY, 0);
    chk("reset_ram_ad", bus.RAM_AD, 0);
    chk("reset_m_di", bus.M_DI, 0);
    RESET = 1'b0;

    // simultaneous requests right after reset: main first, sub 3 cycles later
    set_m(1, 1, 10'h001, 8'h11);
    set_s(1, 1, 10'h002, 8'h22);
    wait_ack(1'b0, 10, lat);
    chk("pair_main_lat", lat, 3);
    chk("pair_main_sub_ack", bus.S_ACK, 0);
    bus.M_REQ = 1'b0;
    wait_ack(1'b1, 10, lat);
    chk("pair_sub_lat", lat, 3);
    bus.S_REQ = 1'b0;

    // main write 0x155 = A5, then read it back
    set_m(1, 1, 10'h155, 8'hA5);
    tick();
    chk("wr_ram_we", bus.RAM_WE, 1);
    chk("wr_ram_ad", bus.RAM_AD, 10'h155);
    chk("wr_ram_wd", bus.RAM_WD, 8'hA5);
    wait_ack(1'b0, 10, lat);
    chk("wr_ack_lat", lat, 2);
    bus.M_REQ = 1'b0;
    tick();
    set_m(1, 0, 10'h155, 8'h00);
    wait_ack(1'b0, 10, lat);
    chk("rd_ack_lat", lat, 3);
    chk("rd_m_di", bus.M_DI, 8'hA5);
    bus.M_REQ = 1'b0;
    tick();

    // after a main grant: sub write 0x3FF=5A races main read of 0x3FF
    set_s(1, 1, 10'h3FF, 8'h5A);
    set_m(1, 0, 10'h3FF, 8'h00);
`ifdef SHARED_RAM_MAIN_PRIO_EN
    wait_ack(1'b0, 10, lat);
    chk("race_main_lat", lat, 3);
    chk("race_m_di_old", bus.M_DI, 8'h00);
    bus.M_REQ = 1'b0;
    wait_ack(1'b1, 10, lat);
    chk("race_sub_lat", lat, 3);
`else
    wait_ack(1'b1, 10, lat);
    chk("race_sub_lat", lat, 3);
    bus.S_REQ = 1'b0;
    wait_ack(1'b0, 10, lat);
    chk("race_main_lat", lat, 3);
    chk("race_m_di_new", bus.M_DI, 8'h5A);
`endif
    set_m(0, 0, '0, '0);
    set_s(0, 0, '0, '0);
    tick();

    // reset during DONE of a main read aborts it
    set_m(1, 0, 10'h155, 8'h00);
    tick();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rst_no_ack", bus.M_ACK, 0);
    chk("rst_m_di", bus.M_DI, 0);
    chk("rst_idle", bus.BUSY, 0);
    wait_ack(1'b0, 10, lat);
    chk("rst_retry_lat", lat, 3);
    chk("rst_retry_di", bus.M_DI, 8'hA5);
    bus.M_REQ = 1'b0;
    tick();

    // both held: the requester in its ACK cycle is masked, so grants alternate
`ifdef SHARED_RAM_MAIN_PRIO_EN
    first_sub = 1'b0;
`else
    first_sub = 1'b1;
`endif
    set_m(1, 0, 10'h100, 8'h00);
    set_s(1, 0, 10'h200, 8'h00);
    for (int i = 0; i < 40 && seq.size() < 4; i++) begin
      tick();
      if (bus.M_ACK === 1'b1) seq.push_back(1'b0);
      if (bus.S_ACK === 1'b1) seq.push_back(1'b1);
    end
    chk("alt_count", seq.size(), 4);
    for (int k = 0; k < seq.size() && k < 4; k++)
      chk($sformatf("alt_grant%0d", k), seq[k], first_sub ^ k[0]);
    set_m(0, 0, '0, '0);
    set_s(0, 0, '0, '0);
    repeat (4) tick();

    // address change mid-request is ignored
    set_m(1, 0, 10'h010, 8'h00);
    tick();
    bus.M_AD = 10'h020;
    chk("hold_ad_access", bus.RAM_AD, 10'h010);
    tick();
    chk("hold_ad_done", bus.RAM_AD, 10'h010);
    tick();
    chk("hold_ack", bus.M_ACK, 1);
    bus.M_REQ = 1'b0;
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (bus.M_ACK === 1'b1 || !bus.M_REQ) begin
        if ($urandom_range(0, 3) != 0) set_m(1, 1'($urandom_range(0, 1)), ad_pick(), DW'($urandom));
        else bus.M_REQ = 1'b0;
      end else if ($urandom_range(0, 15) == 0) bus.M_AD = ad_pick();
      else if ($urandom_range(0, 63) == 0) bus.M_REQ = 1'b0;
      if (bus.S_ACK === 1'b1 || !bus.S_REQ) begin
        if ($urandom_range(0, 3) != 0) set_s(1, 1'($urandom_range(0, 1)), ad_pick(), DW'($urandom));
        else bus.S_REQ = 1'b0;
      end else if ($urandom_range(0, 15) == 0) bus.S_DO = DW'($urandom);
      else if ($urandom_range(0, 63) == 0) bus.S_REQ = 1'b0;
      RESET = ($urandom_range(0, 199) == 0);
      tick();
    end
    RESET = 1'b0;
    set_m(0, 0, '0, '0);
    set_s(0, 0, '0, '0);
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
